// File: rtl/angle_steps_pkg.sv
// Shared types and fixed-point helpers for the angle-to-steps converter.
// Holds the FSM state encoding, default scaling constants and the rounding shift.
package angle_steps_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_RND  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int unsigned K_STEPS_PER_RAD = 97785;  // 95.4930 steps/rad, Q.10
  localparam int          TH_FRAC         = 10;
  localparam int          K_FRAC          = 10;
  localparam int          K_W             = 18;
  localparam int          RS_W            = 64;

  // Divide by 2^f rounding half away from zero. Rounding the magnitude keeps
  // the result symmetric about zero, so +x and -x map to steps of equal size.
  function automatic logic signed [RS_W-1:0] round_shift(
    input logic signed [RS_W-1:0] prod,
    input int                     f
  );
    logic [RS_W-1:0] mag;
    logic [RS_W-1:0] half;
    if (f <= 0) return prod;
    half = RS_W'(1) << (f - 1);
    mag  = prod[RS_W-1] ? $unsigned(-prod) : $unsigned(prod);
    mag  = (mag + half) >> f;
    return prod[RS_W-1] ? -$signed(mag) : $signed(mag);
  endfunction

endpackage

// File: rtl/angle_to_steps_converter_step_saturate.sv
// Splits a signed step request into direction and a clamped magnitude.
// Purely combinational; sat flags any request larger than STEP_W bits can carry.
module step_saturate
  import angle_steps_pkg::*;
#(
  parameter int V_W    = 17,
  parameter int STEP_W = 9
) (
  input  logic signed [V_W-1:0]    v,
  output logic        [STEP_W-1:0] issued,
  output logic                     dir,
  output logic                     sat
);

  localparam int             CW    = ((V_W > STEP_W) ? V_W : STEP_W) + 1;
  localparam logic [CW-1:0]  MAX_X = CW'((64'd1 << STEP_W) - 64'd1);

  logic [V_W-1:0] mag;
  logic [CW-1:0]  mag_x;

  // NOTE: every output is assigned on every path through this block, so no latch is inferred.
  always_comb begin
    mag    = v[V_W-1] ? $unsigned(-v) : $unsigned(v);
    mag_x  = CW'(mag);
    sat    = (mag_x > MAX_X);
    issued = sat ? MAX_X[STEP_W-1:0] : mag_x[STEP_W-1:0];
    dir    = ~v[V_W-1];
  end

endmodule

// File: rtl/angle_to_steps_converter.sv
// Converts NCH signed fixed-point joint angles into step magnitudes and directions,
// sharing one multiplier across channels, with an optional position-relative delta mode.
module angle_to_steps_converter #(
  parameter int          NCH             = 2,
  parameter int          TH_W            = 13,
  parameter int          TH_FRAC         = angle_steps_pkg::TH_FRAC,
  parameter int unsigned K_STEPS_PER_RAD = angle_steps_pkg::K_STEPS_PER_RAD,
  parameter int          K_W             = angle_steps_pkg::K_W,
  parameter int          K_FRAC          = angle_steps_pkg::K_FRAC,
  parameter int          STEP_W          = 9,
  parameter int          POS_W           = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    delta_mode,
  input  logic [NCH*TH_W-1:0]     th,
  output logic                    busy,
  output logic                    done,
  output logic [NCH*STEP_W-1:0]   steps,
  output logic [NCH-1:0]          dir,
  output logic [NCH-1:0]          sat
);

  import angle_steps_pkg::*;

  // One spare product bit keeps -2^(TH_W-1) * K from overflowing.
  localparam int              P_W     = TH_W + K_W + 1;
  localparam int              F       = TH_FRAC + K_FRAC;
  localparam int              V_W     = POS_W + 1;
  localparam int              CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

  state_t                   state, state_nxt;
  logic                     accept;
  logic [CH_W-1:0]          ch;
  logic [NCH*TH_W-1:0]      th_q;
  logic                     delta_q;
  logic signed [P_W-1:0]    prod;
  logic signed [POS_W-1:0]  pos [NCH];

  logic signed [TH_W-1:0]   th_sel;
  logic signed [P_W-1:0]    th_ext;
  logic signed [P_W-1:0]    k_ext;
  logic signed [POS_W-1:0]  abs_steps;
  logic signed [POS_W-1:0]  pos_cur;
  logic signed [V_W-1:0]    v;
  logic        [STEP_W-1:0] issued;
  logic        [POS_W-1:0]  issued_ext;
  logic                     v_dir;
  logic                     v_sat;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = S_MUL;
      end
      S_MUL: begin
        busy      = 1'b1;
        state_nxt = S_RND;
      end
      S_RND: begin
        busy      = 1'b1;
        state_nxt = (ch == LAST_CH) ? S_DONE : S_MUL;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ch    <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        ch <= '0;
      else if (state == S_RND && ch != LAST_CH)
        ch <= ch + CH_W'(1);
    end
  end

  // Operand latches and the product are always written before they are read.
  always_ff @(posedge clk) begin
    if (accept) begin
      th_q    <= th;
      delta_q <= delta_mode;
    end
    if (state == S_MUL)
      prod <= th_ext * k_ext;
  end

  always_comb begin
    th_sel     = th_q[ch*TH_W +: TH_W];
    th_ext     = P_W'(th_sel);
    k_ext      = $signed({{(P_W-K_W){1'b0}}, K_W'(K_STEPS_PER_RAD)});
    abs_steps  = POS_W'(round_shift(RS_W'(prod), F));
    pos_cur    = pos[ch];
    v          = delta_q ? (V_W'(abs_steps) - V_W'(pos_cur)) : V_W'(abs_steps);
    issued_ext = POS_W'(issued);
  end

  step_saturate #(
    .V_W    (V_W),
    .STEP_W (STEP_W)
  ) u_step_saturate (
    .v      (v),
    .issued (issued),
    .dir    (v_dir),
    .sat    (v_sat)
  );

  // NOTE: the position array is reset because delta mode reads it before any write.
  always_ff @(posedge clk) begin
    if (reset) begin
      steps <= '0;
      dir   <= '0;
      sat   <= '0;
      for (int i = 0; i < NCH; i++) pos[i] <= '0;
    end else if (state == S_RND) begin
      steps[ch*STEP_W +: STEP_W] <= issued;
      dir[ch]                    <= v_dir;
      sat[ch]                    <= v_sat;
      // Delta mode tracks what was actually issued, so a clamped remainder
      // shows up again in the next conversion.
      if (delta_q)
        pos[ch] <= v_dir ? (pos_cur + $signed(issued_ext)) : (pos_cur - $signed(issued_ext));
      else
        pos[ch] <= abs_steps;
    end
  end

endmodule

// File: tb/tb_angle_to_steps_converter.sv
// Directed bench for angle_to_steps_converter: a vector table on the default
// two-channel build plus hand sequences for start handling, reset abort and a 3-channel build.
module tb_angle_to_steps_converter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, delta_mode;
  logic [25:0] th;
  logic        busy, done;
  logic [17:0] steps;
  logic [1:0]  dir, sat;

  logic        start3, delta3;
  logic [38:0] th3;
  logic        busy3, done3;
  logic [35:0] steps3;
  logic [2:0]  dir3, sat3;

  int n_cmp  = 0;
  int n_fail = 0;
  int lat, bsy;

  always #5 clk = ~clk;

  angle_to_steps_converter dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .delta_mode (delta_mode),
    .th         (th),
    .busy       (busy),
    .done       (done),
    .steps      (steps),
    .dir        (dir),
    .sat        (sat)
  );

  angle_to_steps_converter #(
    .NCH    (3),
    .STEP_W (12)
  ) dut3 (
    .clk        (clk),
    .reset      (reset),
    .start      (start3),
    .delta_mode (delta3),
    .th         (th3),
    .busy       (busy3),
    .done       (done3),
    .steps      (steps3),
    .dir        (dir3),
    .sat        (sat3)
  );

  typedef struct {
    logic        dm;
    logic [12:0] t0;
    logic [12:0] t1;
    logic [17:0] steps;  // {ch1, ch0}
    logic [1:0]  dir;
    logic [1:0]  sat;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Starts one conversion on the 2-channel build; returns edges to done and busy cycles.
  task automatic convert2(input logic dm, input logic [12:0] t0, input logic [12:0] t1,
                          output int l, output int b);
    @(posedge clk); #1;
    th = {t1, t0}; delta_mode = dm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    l = 0;
    b = busy ? 1 : 0;
    while (l < 50) begin
      @(posedge clk); #1;
      l++;
      if (done) break;
      if (busy) b++;
    end
  endtask

  task automatic convert3(input logic dm, input logic [12:0] t0, input logic [12:0] t1,
                          input logic [12:0] t2, output int l, output int b);
    @(posedge clk); #1;
    th3 = {t2, t1, t0}; delta3 = dm; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    l = 0;
    b = busy3 ? 1 : 0;
    while (l < 50) begin
      @(posedge clk); #1;
      l++;
      if (done3) break;
      if (busy3) b++;
    end
  endtask

  initial begin
    int ndone, d1, d2, nd;

    vecs[0] = '{1'b0, 13'd1024, -13'sd1024, {9'd95,  9'd95},  2'b01, 2'b00};
    vecs[1] = '{1'b0, 13'd3217, 13'd0,      {9'd0,   9'd300}, 2'b11, 2'b00};
    vecs[2] = '{1'b0, 13'd6,    -13'sd5,    {9'd0,   9'd1},   2'b11, 2'b00};
    vecs[3] = '{1'b0, -13'sd6,  13'd5,      {9'd0,   9'd1},   2'b10, 2'b00};
    vecs[4] = '{1'b0, 13'd4095, 13'h1000,   {9'd382, 9'd382}, 2'b01, 2'b00};
    vecs[5] = '{1'b0, 13'd0,    13'd0,      {9'd0,   9'd0},   2'b11, 2'b00};
    vecs[6] = '{1'b1, 13'h1000, 13'd0,      {9'd0,   9'd382}, 2'b10, 2'b00};
    vecs[7] = '{1'b1, 13'd4095, 13'd0,      {9'd0,   9'd511}, 2'b11, 2'b01};
    vecs[8] = '{1'b1, 13'd4095, 13'd0,      {9'd0,   9'd253}, 2'b11, 2'b00};
    vecs[9] = '{1'b1, 13'd4095, 13'd1024,   {9'd95,  9'd0},   2'b11, 2'b00};

    reset = 1'b1; start = 1'b0; delta_mode = 1'b0; th = '0;
    start3 = 1'b0; delta3 = 1'b0; th3 = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    check("rst_busy",  busy,  0);
    check("rst_done",  done,  0);
    check("rst_steps", steps, 0);
    check("rst_dir",   dir,   0);
    check("rst_sat",   sat,   0);
    check("rst_steps3", steps3, 0);

    for (int i = 0; i < 10; i++) begin
      convert2(vecs[i].dm, vecs[i].t0, vecs[i].t1, lat, bsy);
      check($sformatf("v%0d_latency", i), lat,   4);
      check($sformatf("v%0d_busy", i),    bsy,   4);
      check($sformatf("v%0d_steps", i),   steps, vecs[i].steps);
      check($sformatf("v%0d_dir", i),     dir,   vecs[i].dir);
      check($sformatf("v%0d_sat", i),     sat,   vecs[i].sat);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_width", i), done, 0);
    end

    // start held through busy and DONE: stray start ignored, re-accepted only from IDLE
    @(posedge clk); #1;
    th = {-13'sd1024, 13'sd1024}; delta_mode = 1'b0; start = 1'b1;
    ndone = 0; d1 = -1; d2 = -1;
    for (int e = 0; e < 15; e++) begin
      @(posedge clk); #1;
      if (e == 0) th = {13'd100, 13'd100};
      if (e == 6) start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          d1 = e;
          check("held_first_steps", steps, {9'd95, 9'd95});
          check("held_first_dir",   dir,   2'b01);
          check("held_busy_in_done", busy, 0);
          th = {13'd0, 13'd3217};
        end else begin
          d2 = e;
        end
      end
      if (e == 5) check("hold_after_done", steps, {9'd95, 9'd95});
      if (e >= 11) check($sformatf("hold_e%0d", e), steps, {9'd0, 9'd300});
    end
    check("held_done_count", ndone, 2);
    check("held_first_edge", d1, 4);
    check("held_second_edge", d2, 10);

    // reset during RND of channel 0 aborts and clears positions
    @(posedge clk); #1;
    th = {13'd0, 13'd1024}; delta_mode = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy",  busy,  0);
    check("abort_done",  done,  0);
    check("abort_steps", steps, 0);
    check("abort_dir",   dir,   0);
    check("abort_sat",   sat,   0);
    nd = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("abort_no_done", nd, 0);
    convert2(1'b1, 13'd1024, 13'd0, lat, bsy);
    check("post_abort_latency", lat, 4);
    check("post_abort_steps", steps, {9'd0, 9'd95});
    check("post_abort_dir",   dir,   2'b11);

    // three-channel build: latency and packed offsets
    convert3(1'b0, 13'd1024, 13'h1000, 13'd3217, lat, bsy);
    check("n3_latency", lat, 6);
    check("n3_busy",    bsy, 6);
    check("n3_steps",   steps3, {12'd300, 12'd382, 12'd95});
    check("n3_dir",     dir3,   3'b101);
    check("n3_sat",     sat3,   3'b000);
    convert3(1'b1, 13'd0, 13'd4095, 13'h1000, lat, bsy);
    check("n3_delta_latency", lat, 6);
    check("n3_delta_steps",   steps3, {12'd682, 12'd764, 12'd95});
    check("n3_delta_dir",     dir3,   3'b010);
    check("n3_delta_sat",     sat3,   3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
